// File: rtl/cfg_seq_pkg.sv
// Shared types and constants for the configuration-word sequencer.
//
// Contents:
//   state_t        - sequencer FSM states
//   CFG_END        - end-of-table marker word
//   CFG_DELAY_TAG  - upper byte that marks a delay pseudo-word
//   is_busy()      - true for every state that is not IDLE, DONE or ERROR
package cfg_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND_DEV,
        SEND_REG,
        SEND_DATA,
        WAIT_ACK,
        DELAY,
        NEXT,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] CFG_END       = 16'hFFFF;
    localparam logic [7:0]  CFG_DELAY_TAG = 8'hFE;

    // IDLE, DONE and ERROR are the resting states that accept a new start.
    function automatic logic is_busy(input state_t s);
        return !(s == IDLE || s == DONE || s == ERROR);
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter for delay pseudo-words.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   load   - load the counter with ticks * DELAY_UNIT
//   en     - count down by one per cycle while nonzero
//   ticks  - delay length in DELAY_UNIT ticks
//   zero   - counter has reached zero
module cfg_delay_timer #(
    parameter int DELAY_UNIT = 1000,
    parameter int CNT_W      = $clog2(255 * DELAY_UNIT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] ticks,
    output logic       zero
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority so the sequencer can reload on every delay word;
    // the counter parks at zero once it gets there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(ticks) * CNT_W'(DELAY_UNIT);
        end else if (en && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/axis_cfg_sequencer.sv
// Configuration-word sequencer: pulls {reg_addr, reg_data} words from an
// AXI-Stream source and frames each one as a 3-byte I2C write
// (device address, register, data) towards the I2C master's byte stream.
// Handles NACK retries, delay pseudo-words (16'hFExx) and the end-of-table
// marker (16'hFFFF).
//
// Ports:
//   clk_i, arstn_i           - clock, asynchronous active-low reset
//   start_i                  - one-cycle run request (honoured when not busy)
//   s_axis_tvalid/tready/tdata        - config words in
//   m_axis_tvalid/tready/tdata/tlast  - bytes out to the I2C master
//   i2c_done_i, i2c_nack_i   - transaction completion pulse and its NACK flag
//   busy_o, done_o, error_o  - run status
//   word_idx_o               - index of the word currently being processed
module axis_cfg_sequencer
    import cfg_seq_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h21,
    parameter int         MEM_DEPTH  = 24,
    parameter int         MAX_RETRY  = 3,
    parameter int         DELAY_UNIT = 1000,
    parameter int         WORD_W     = 16,
    localparam int        IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              start_i,

    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [WORD_W-1:0] s_axis_tdata,

    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tlast,

    input  logic              i2c_done_i,
    input  logic              i2c_nack_i,

    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [IDX_W-1:0]  word_idx_o
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CNT_W   = $clog2(255 * DELAY_UNIT + 1);

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   word_r;
    logic [IDX_W-1:0]    word_idx;
    logic [RETRY_W-1:0]  retry_cnt;
    logic                timer_load;
    logic                timer_zero;
    logic                start_ok;
    logic                last_word;
    logic                can_retry;
    logic [7:0]          word_hi;
    logic [7:0]          word_lo;

    assign word_hi   = word_r[WORD_W-1 -: 8];
    assign word_lo   = word_r[7:0];
    assign start_ok  = start_i && !is_busy(state);
    assign last_word = (word_idx == IDX_W'(MEM_DEPTH - 1));
    assign can_retry = (retry_cnt < RETRY_W'(MAX_RETRY));

    cfg_delay_timer #(
        .DELAY_UNIT (DELAY_UNIT),
        .CNT_W      (CNT_W)
    ) u_delay_timer (
        .clk   (clk_i),
        .rst_n (arstn_i),
        .load  (timer_load),
        .en    (state == DELAY),
        .ticks (word_lo),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and stream outputs. Byte outputs depend only on state and
    // the latched word, so they stay stable while the I2C master stalls.
    always_comb begin
        state_next    = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        timer_load    = 1'b0;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    state_next = FETCH;
                end
            end

            FETCH: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    state_next = DECODE;
                end
            end

            DECODE: begin
                if (word_r == WORD_W'(CFG_END)) begin
                    state_next = DONE;
                end else if (word_hi == CFG_DELAY_TAG) begin
                    timer_load = 1'b1;
                    state_next = DELAY;
                end else begin
                    state_next = SEND_DEV;
                end
            end

            SEND_DEV: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {DEV_ADDR, 1'b0};
                if (m_axis_tready) begin
                    state_next = SEND_REG;
                end
            end

            SEND_REG: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = word_hi;
                if (m_axis_tready) begin
                    state_next = SEND_DATA;
                end
            end

            SEND_DATA: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = word_lo;
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) begin
                    state_next = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (i2c_done_i) begin
                    if (!i2c_nack_i) begin
                        state_next = NEXT;
                    end else if (can_retry) begin
                        state_next = SEND_DEV;
                    end else begin
                        state_next = ERROR;
                    end
                end
            end

            DELAY: begin
                if (timer_zero) begin
                    state_next = NEXT;
                end
            end

            NEXT: begin
                state_next = last_word ? DONE : FETCH;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word latch, table index and retry bookkeeping. A retry resends the
    // already-latched word, so no refetch is needed.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            word_r    <= '0;
            word_idx  <= '0;
            retry_cnt <= '0;
        end else begin
            if (start_ok) begin
                word_idx  <= '0;
                retry_cnt <= '0;
            end
            if (state == FETCH && s_axis_tvalid) begin
                word_r <= s_axis_tdata;
            end
            if (state == WAIT_ACK && i2c_done_i && i2c_nack_i && can_retry) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end
            if (state == NEXT) begin
                retry_cnt <= '0;
                if (!last_word) begin
                    word_idx <= word_idx + IDX_W'(1);
                end
            end
        end
    end

    assign busy_o     = is_busy(state);
    assign done_o     = (state == DONE);
    assign error_o    = (state == ERROR);
    assign word_idx_o = word_idx;

endmodule

// File: tb/tb_axis_cfg_sequencer.sv
// Directed testbench for axis_cfg_sequencer. A word source, an I2C byte sink
// and an I2C completion responder run in the background; each test task
// loads them, runs the sequencer and compares against hand-computed values.
module tb_axis_cfg_sequencer;

    localparam int DU = 10;

    logic        clk;
    logic        arstn;
    logic        start;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        i2c_done;
    logic        i2c_nack;
    logic        busy;
    logic        done;
    logic        error;
    logic [4:0]  word_idx;

    axis_cfg_sequencer #(
        .DEV_ADDR   (7'h21),
        .MEM_DEPTH  (24),
        .MAX_RETRY  (3),
        .DELAY_UNIT (DU),
        .WORD_W     (16)
    ) dut (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .start_i       (start),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .i2c_done_i    (i2c_done),
        .i2c_nack_i    (i2c_nack),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error),
        .word_idx_o    (word_idx)
    );

    int checks = 0;
    int passed = 0;

    logic [15:0] src_q[$];
    bit          nack_q[$];
    logic [8:0]  got_q[$];
    logic [8:0]  exp_q[$];
    int          acc_cyc_q[$];
    int          hs_cyc_q[$];
    int          cyc = 0;
    int          stall_viol = 0;
    bit          src_gap = 0;
    bit          sink_rand = 0;
    bit          sink_hold = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Word source: holds tvalid until accepted, optional random gaps.
    initial begin
        bit take;
        take     = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 16'h0000;
        forever begin
            @(negedge clk);
            if (take && src_q.size() > 0) begin
                void'(src_q.pop_front());
                acc_cyc_q.push_back(cyc);
            end
            if (src_q.size() > 0 && (s_tvalid || !src_gap || $urandom_range(0, 2) == 0)) begin
                s_tvalid = 1'b1;
                s_tdata  = src_q[0];
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = 16'h0000;
            end
            take = s_tvalid && s_tready;
        end
    end

    // Byte sink plus I2C completion responder (done pulse 3 cycles after tlast).
    initial begin
        int         ack_timer;
        bit         prev_stall;
        logic [8:0] prev_byte;
        ack_timer  = 0;
        prev_stall = 1'b0;
        prev_byte  = 9'h000;
        m_tready   = 1'b0;
        i2c_done   = 1'b0;
        i2c_nack   = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_done) begin
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
            if (ack_timer > 0) begin
                ack_timer--;
                if (ack_timer == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                end
            end
            if (sink_hold) begin
                m_tready = m_tvalid && (m_tdata == 8'h42);
            end else if (sink_rand) begin
                m_tready = ($urandom_range(0, 1) == 1);
            end else begin
                m_tready = 1'b1;
            end
            if (prev_stall && m_tvalid && ({m_tlast, m_tdata} !== prev_byte)) begin
                stall_viol++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_byte  = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                got_q.push_back({m_tlast, m_tdata});
                hs_cyc_q.push_back(cyc);
                if (m_tlast) begin
                    ack_timer = 3;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_bench();
        got_q.delete();
        exp_q.delete();
        acc_cyc_q.delete();
        hs_cyc_q.delete();
        nack_q.delete();
    endtask

    task automatic push_frame(input logic [15:0] w);
        exp_q.push_back({1'b0, 8'h42});
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({1'b1, w[7:0]});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL reset_error got %b want 0", error); else passed++;
        checks++; if (word_idx !== 5'd0) $display("[TB] FAIL reset_word_idx got %0d want 0", word_idx); else passed++;
        checks++; if (s_tready !== 1'b0) $display("[TB] FAIL reset_s_tready got %b want 0", s_tready); else passed++;
        checks++; if ({m_tvalid, m_tlast, m_tdata} !== 10'h000) $display("[TB] FAIL reset_m_axis got %h want 000", {m_tvalid, m_tlast, m_tdata}); else passed++;
        arstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        clear_bench();
        src_q = '{16'h1234, 16'h5678, 16'hFFFF};
        push_frame(16'h1234);
        push_frame(16'h5678);
        pulse_start();
        wait_idle(1000, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL basic_timeout got busy=%b want 0", busy); else passed++;
        checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL basic_byte_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL basic_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
        checks++; if (done !== 1'b1) $display("[TB] FAIL basic_done got %b want 1", done); else passed++;
        checks++; if (word_idx !== 5'd2) $display("[TB] FAIL basic_word_idx got %0d want 2", word_idx); else passed++;
        checks++; if (acc_cyc_q.size() !== 3) $display("[TB] FAIL basic_accepts got %0d want 3", acc_cyc_q.size()); else passed++;
    endtask

    task automatic test_retry();
        bit to;
        clear_bench();
        src_q  = '{16'hAB01, 16'hFFFF};
        nack_q = '{1'b1, 1'b1};
        repeat (3) push_frame(16'hAB01);
        pulse_start();
        wait_idle(1000, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL retry_timeout got busy=%b want 0", busy); else passed++;
        checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL retry_byte_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL retry_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
        checks++; if (acc_cyc_q.size() !== 2) $display("[TB] FAIL retry_accepts got %0d want 2", acc_cyc_q.size()); else passed++;
        checks++; if (error !== 1'b0) $display("[TB] FAIL retry_error got %b want 0", error); else passed++;
        checks++; if (done !== 1'b1) $display("[TB] FAIL retry_done got %b want 1", done); else passed++;
        checks++; if (word_idx !== 5'd1) $display("[TB] FAIL retry_word_idx got %0d want 1", word_idx); else passed++;
    endtask

    task automatic test_error();
        bit to;
        clear_bench();
        // Word 0 ACKed, word 1 NACKed four times: initial send plus 3 retries.
        src_q  = '{16'h1234, 16'hAB01};
        nack_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        push_frame(16'h1234);
        repeat (4) push_frame(16'hAB01);
        pulse_start();
        wait_idle(1000, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL error_timeout got busy=%b want 0", busy); else passed++;
        checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL error_byte_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL error_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
        checks++; if (error !== 1'b1) $display("[TB] FAIL error_flag got %b want 1", error); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL error_done got %b want 0", done); else passed++;
        checks++; if (word_idx !== 5'd1) $display("[TB] FAIL error_word_idx got %0d want 1", word_idx); else passed++;
        src_q.push_back(16'h1111);
        repeat (20) @(negedge clk);
        checks++; if (acc_cyc_q.size() !== 2) $display("[TB] FAIL error_sticky_accepts got %0d want 2", acc_cyc_q.size()); else passed++;
        checks++; if (error !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL error_sticky got error=%b busy=%b want 1 0", error, busy); else passed++;

        clear_bench();
        src_q.push_back(16'hFFFF);
        push_frame(16'h1111);
        pulse_start();
        checks++; if (word_idx !== 5'd0) $display("[TB] FAIL restart_word_idx got %0d want 0", word_idx); else passed++;
        checks++; if (error !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL restart_status got error=%b busy=%b want 0 1", error, busy); else passed++;
        wait_idle(1000, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL restart_timeout got busy=%b want 0", busy); else passed++;
        checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL restart_byte_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL restart_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
        checks++; if (done !== 1'b1 || word_idx !== 5'd1) $display("[TB] FAIL restart_end got done=%b idx=%0d want 1 1", done, word_idx); else passed++;
    endtask

    task automatic test_delay();
        bit to;
        clear_bench();
        src_q = '{16'hFE02, 16'hFE00, 16'h1234, 16'hFFFF};
        push_frame(16'h1234);
        pulse_start();
        wait_idle(2000, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL delay_timeout got busy=%b want 0", busy); else passed++;
        checks++; if (acc_cyc_q.size() !== 4) $display("[TB] FAIL delay_accepts got %0d want 4", acc_cyc_q.size()); else passed++;
        if (acc_cyc_q.size() >= 3) begin
            // Accept-to-accept: DECODE + (2*DU+1) DELAY cycles + NEXT + FETCH.
            checks++; if (acc_cyc_q[1] - acc_cyc_q[0] !== 2 * DU + 4) $display("[TB] FAIL delay_gap got %0d want %0d", acc_cyc_q[1] - acc_cyc_q[0], 2 * DU + 4); else passed++;
            // A zero-tick delay word only costs DECODE, one DELAY cycle, NEXT, FETCH.
            checks++; if (acc_cyc_q[2] - acc_cyc_q[1] !== 4) $display("[TB] FAIL delay_zero_gap got %0d want 4", acc_cyc_q[2] - acc_cyc_q[1]); else passed++;
            checks++; if (hs_cyc_q.size() == 0 || hs_cyc_q[0] <= acc_cyc_q[2]) $display("[TB] FAIL delay_quiet got %0d handshakes before word 2", hs_cyc_q.size()); else passed++;
        end
        checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL delay_byte_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL delay_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
        checks++; if (done !== 1'b1 || word_idx !== 5'd3) $display("[TB] FAIL delay_end got done=%b idx=%0d want 1 3", done, word_idx); else passed++;
    endtask

    task automatic test_stall();
        bit to;
        int viol0;
        clear_bench();
        viol0     = stall_viol;
        src_gap   = 1'b1;
        sink_rand = 1'b1;
        src_q = '{16'h0102, 16'h0304, 16'h0506, 16'hFFFF};
        push_frame(16'h0102);
        push_frame(16'h0304);
        push_frame(16'h0506);
        pulse_start();
        wait_idle(3000, to);
        src_gap   = 1'b0;
        sink_rand = 1'b0;
        checks++; if (to !== 1'b0) $display("[TB] FAIL stall_timeout got busy=%b want 0", busy); else passed++;
        checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL stall_byte_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL stall_byte%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
        checks++; if (stall_viol - viol0 !== 0) $display("[TB] FAIL stall_stable got %0d changes want 0", stall_viol - viol0); else passed++;
        checks++; if (done !== 1'b1) $display("[TB] FAIL stall_done got %b want 1", done); else passed++;
    endtask

    task automatic test_exhaust();
        bit          to;
        logic [15:0] w;
        clear_bench();
        for (int i = 0; i < 24; i++) begin
            w = {8'(i + 1), 8'(i + 8'h40)};
            src_q.push_back(w);
            push_frame(w);
        end
        // A 25th word must never be pulled.
        src_q.push_back(16'hFFFF);
        pulse_start();
        wait_idle(5000, to);
        checks++; if (to !== 1'b0) $display("[TB] FAIL exhaust_timeout got busy=%b want 0", busy); else passed++;
        checks++; if (got_q.size() !== 72) $display("[TB] FAIL exhaust_byte_count got %0d want 72", got_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                checks++;
                $display("[TB] FAIL exhaust_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
                break;
            end
        end
        checks++; if (acc_cyc_q.size() !== 24) $display("[TB] FAIL exhaust_accepts got %0d want 24", acc_cyc_q.size()); else passed++;
        checks++; if (done !== 1'b1 || word_idx !== 5'd23) $display("[TB] FAIL exhaust_end got done=%b idx=%0d want 1 23", done, word_idx); else passed++;
        src_q.delete();
    endtask

    task automatic test_reset_mid();
        bit found;
        clear_bench();
        sink_hold = 1'b1;
        src_q = '{16'h1234, 16'hFFFF};
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_tvalid && m_tdata == 8'h12) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) $display("[TB] FAIL midreset_reach got found=%b want 1", found); else passed++;
        #2;
        arstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy got %b want 0", busy); else passed++;
        checks++; if ({m_tvalid, m_tlast, m_tdata} !== 10'h000) $display("[TB] FAIL midreset_m_axis got %h want 000", {m_tvalid, m_tlast, m_tdata}); else passed++;
        checks++; if (s_tready !== 1'b0) $display("[TB] FAIL midreset_s_tready got %b want 0", s_tready); else passed++;
        checks++; if ({done, error, word_idx} !== 7'd0) $display("[TB] FAIL midreset_status got %h want 00", {done, error, word_idx}); else passed++;
        sink_hold = 1'b0;
        src_q.delete();
        @(negedge clk);
        arstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        arstn = 1'b0;
        start = 1'b0;
        test_reset();
        test_basic();
        test_retry();
        test_error();
        test_delay();
        test_stall();
        test_exhaust();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
